// File: rtl/scene_pkg.sv
// Shared raster timing, sprite geometry, palette and pipe word layout for scene_render.
package scene_pkg;

  localparam int H_VIS    = 640;
  localparam int H_TOTAL  = 800;
  localparam int HS_START = 656;
  localparam int HS_END   = 752;

  localparam int V_VIS    = 480;
  localparam int V_TOTAL  = 525;
  localparam int VS_START = 490;
  localparam int VS_END   = 492;

  localparam int BIRD_X    = 40;
  localparam int BIRD_W    = 16;
  localparam int BIRD_H    = 16;
  localparam int PIPE_W    = 50;
  localparam int PIPE_HEAD = 23;
  localparam int COIN_LEN  = 16;

  localparam logic [11:0] SKY_1P_C    = 12'h6CF;
  localparam logic [11:0] SKY_2P_C    = 12'h249;
  localparam logic [11:0] PIPE_C      = 12'h2A2;
  localparam logic [11:0] PIPE_HEAD_C = 12'h1F1;
  localparam logic [11:0] COIN_C      = 12'hFD0;
  localparam logic [11:0] BIRD_UP_C   = 12'hF80;
  localparam logic [11:0] BIRD_DN_C   = 12'hF40;

  typedef struct packed {
    logic [7:0] gap;
    logic [9:0] x;
    logic [9:0] y;
  } pipe_t;

endpackage

// File: rtl/scene_render_pipe_hit.sv
// Combinational body/head coverage test of one pipe at a pixel (x, game y).
// Head spans exist only when SCENE_PIPE_HEAD_EN is defined; otherwise they read as body.
module pipe_hit
  import scene_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] gy,
  input  pipe_t      pipe,
  output logic       body,
  output logic       head
);

  logic [10:0] x_end;
  logic [10:0] gap_end;
  logic        in_x;
  logic        in_gap;

  // 11-bit sums so a pipe near the right edge or a large gap never wraps back on screen
  assign x_end   = 11'(pipe.x) + 11'(PIPE_W);
  assign gap_end = 11'(pipe.y) + 11'(pipe.gap);
  assign in_x    = (x >= pipe.x) && (11'(x) < x_end);
  assign in_gap  = (gy >= pipe.y) && (11'(gy) < gap_end);
  assign body    = in_x && !in_gap;

`ifdef SCENE_PIPE_HEAD_EN
  logic signed [11:0] low_start;
  logic        [10:0] high_end;
  logic               in_low;
  logic               in_high;

  // Signed lower bound: a gap edge below PIPE_HEAD clamps the head at row 0
  assign low_start = $signed({2'b00, pipe.y}) - $signed(12'(PIPE_HEAD));
  assign high_end  = gap_end + 11'(PIPE_HEAD);
  assign in_low    = ($signed({2'b00, gy}) >= low_start) && (gy < pipe.y);
  assign in_high   = (11'(gy) >= gap_end) && (11'(gy) < high_end);
  assign head      = in_x && (in_low || in_high);
`else
  assign head = 1'b0;
`endif

endmodule

// File: rtl/scene_render.sv
// 640x480@60 VGA renderer: per-frame snapshot of game words, 2-cycle hit/colour pipeline.
// Optional macro SCENE_PIPE_HEAD_EN enables distinct pipe head drawing.
module scene_render
  import scene_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  status,
  input  logic [15:0] bird_y,
  input  logic [31:0] pipe1,
  input  logic [31:0] pipe2,
  input  logic [31:0] pipe3,
  input  logic [31:0] coin,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        h_last;
  logic        v_last;
  logic        snap_now;

  logic        snap_valid;
  logic [1:0]  status_s;
  logic [15:0] bird_s;
  pipe_t       pipe1_s;
  pipe_t       pipe2_s;
  pipe_t       pipe3_s;
  logic        coin_vis_s;
  logic [9:0]  coin_y_s;
  logic [9:0]  coin_x_s;

  logic        unused_bits;
  assign unused_bits = ^{pipe1[31:28], pipe2[31:28], pipe3[31:28], coin[30:20]};

  // Stage 0: raster counters and frame snapshot
  assign h_last   = (hcnt == 10'(H_TOTAL - 1));
  assign v_last   = (vcnt == 10'(V_TOTAL - 1));
  assign snap_now = (hcnt == 10'(H_VIS - 1)) && (vcnt == 10'(V_VIS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_valid <= 1'b0;
      frame_tick <= 1'b0;
      status_s   <= '0;
      bird_s     <= '0;
      pipe1_s    <= '0;
      pipe2_s    <= '0;
      pipe3_s    <= '0;
      coin_vis_s <= 1'b0;
      coin_y_s   <= '0;
      coin_x_s   <= '0;
    end else begin
      frame_tick <= snap_now;
      if (snap_now) begin
        snap_valid <= 1'b1;
        status_s   <= status;
        bird_s     <= bird_y;
        pipe1_s    <= pipe1[27:0];
        pipe2_s    <= pipe2[27:0];
        pipe3_s    <= pipe3[27:0];
        coin_vis_s <= coin[31];
        coin_y_s   <= coin[19:10];
        coin_x_s   <= coin[9:0];
      end
    end
  end

  logic [9:0]  gy;
  logic        vis;
  logic        hs_n;
  logic        vs_n;
  logic        bird_hit;
  logic        coin_hit;
  logic [2:0]  body_hit;
  logic [2:0]  head_hit;
  logic [15:0] gy_w;
  logic [15:0] bird_lo;

  assign gy      = 10'(V_VIS - 1) - vcnt;
  assign vis     = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
  assign hs_n    = !((hcnt >= 10'(HS_START)) && (hcnt < 10'(HS_END)));
  assign vs_n    = !((vcnt >= 10'(VS_START)) && (vcnt < 10'(VS_END)));
  assign gy_w    = {6'b0, gy};
  assign bird_lo = {1'b0, bird_s[14:0]};

  assign bird_hit = (hcnt >= 10'(BIRD_X)) && (hcnt < 10'(BIRD_X + BIRD_W)) &&
                    (gy_w >= bird_lo) && (gy_w < bird_lo + 16'(BIRD_H));
  assign coin_hit = coin_vis_s &&
                    (hcnt >= coin_x_s) && (11'(hcnt) < 11'(coin_x_s) + 11'(COIN_LEN)) &&
                    (gy >= coin_y_s) && (11'(gy) < 11'(coin_y_s) + 11'(COIN_LEN));

  pipe_hit u_pipe1 (.x(hcnt), .gy(gy), .pipe(pipe1_s), .body(body_hit[0]), .head(head_hit[0]));
  pipe_hit u_pipe2 (.x(hcnt), .gy(gy), .pipe(pipe2_s), .body(body_hit[1]), .head(head_hit[1]));
  pipe_hit u_pipe3 (.x(hcnt), .gy(gy), .pipe(pipe3_s), .body(body_hit[2]), .head(head_hit[2]));

  // Stage 1: registered hit flags, visibility and sync
  logic vld_p1;
  logic hs_p1;
  logic vs_p1;
  logic bird_p1;
  logic coin_p1;
  logic head_p1;
  logic body_p1;
  logic bird_up_p1;
  logic sky_2p_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
      bird_p1    <= 1'b0;
      coin_p1    <= 1'b0;
      head_p1    <= 1'b0;
      body_p1    <= 1'b0;
      bird_up_p1 <= 1'b0;
      sky_2p_p1  <= 1'b0;
    end else begin
      vld_p1     <= vis && snap_valid;
      hs_p1      <= hs_n;
      vs_p1      <= vs_n;
      bird_p1    <= bird_hit;
      coin_p1    <= coin_hit;
      head_p1    <= |head_hit;
      body_p1    <= |body_hit;
      bird_up_p1 <= bird_s[15];
      sky_2p_p1  <= status_s[1];
    end
  end

  function automatic logic [11:0] pixel_colour(
    input logic vld, input logic bird, input logic bird_up, input logic coin_h,
    input logic head, input logic body, input logic sky_2p
  );
    if (!vld)   return 12'h000;
    if (bird)   return bird_up ? BIRD_UP_C : BIRD_DN_C;
    if (coin_h) return COIN_C;
    if (head)   return PIPE_HEAD_C;
    if (body)   return PIPE_C;
    return sky_2p ? SKY_2P_C : SKY_1P_C;
  endfunction

  // Stage 2: colour mux and aligned sync outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= pixel_colour(vld_p1, bird_p1, bird_up_p1, coin_p1, head_p1, body_p1, sky_2p_p1);
      hsync <= hs_p1;
      vsync <= vs_p1;
    end
  end

endmodule

// File: tb/tb_scene_render.sv
// Directed bench for scene_render: raster/sync monitor plus table of pixel colour vectors.
module tb_scene_render;
  import scene_pkg::*;

  localparam int FRAME = 800 * 525;
`ifdef SCENE_PIPE_HEAD_EN
  localparam logic [11:0] HEAD_EXP = PIPE_HEAD_C;
`else
  localparam logic [11:0] HEAD_EXP = PIPE_C;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  status;
  logic [15:0] bird_y;
  logic [31:0] pipe1, pipe2, pipe3, coin;
  logic        hsync, vsync, frame_tick;
  logic [11:0] rgb;

  scene_render dut (
    .clk(clk), .rst(rst), .status(status), .bird_y(bird_y),
    .pipe1(pipe1), .pipe2(pipe2), .pipe3(pipe3), .coin(coin),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // cyc equals the raster index the DUT counter holds in this period
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  bit mon_en = 1'b0;
  int sync_err = 0, rgb_err = 0, hs_low_f0 = 0, vs_low_f0 = 0;
  int ticks = 0, first_tick = -1, last_tick = -1;

  always @(negedge clk) begin : monitor
    int   pix, h, v;
    logic exp_hs, exp_vs, blank;
    if (mon_en) begin
      pix = cyc - 2;
      if (pix < 0) begin
        exp_hs = 1'b1; exp_vs = 1'b1; blank = 1'b1;
      end else begin
        h = pix % 800;
        v = (pix / 800) % 525;
        exp_hs = !(h >= 656 && h < 752);
        exp_vs = !(v == 490 || v == 491);
        blank  = (h >= 640) || (v >= 480) || (pix < FRAME);
      end
      if (hsync !== exp_hs || vsync !== exp_vs) sync_err <= sync_err + 1;
      if (blank && rgb !== 12'h000) rgb_err <= rgb_err + 1;
      if (pix >= 0 && pix < FRAME) begin
        if (hsync === 1'b0) hs_low_f0 <= hs_low_f0 + 1;
        if (vsync === 1'b0) vs_low_f0 <= vs_low_f0 + 1;
      end
      if (frame_tick === 1'b1) begin
        ticks <= ticks + 1;
        if (first_tick < 0) first_tick <= cyc;
        last_tick <= cyc;
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic logic [31:0] pipe_word(input int gap, input int x, input int y);
    return {4'b0, 8'(gap), 10'(x), 10'(y)};
  endfunction

  function automatic logic [31:0] coin_word(input logic vis, input int y, input int x);
    return {vis, 11'b0, 10'(y), 10'(x)};
  endfunction

  typedef struct {
    int          frame;
    int          row;
    int          col;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int f, input int r, input int c,
                              input logic [11:0] e, input string n);
    vec_t v;
    v.frame = f; v.row = r; v.col = c; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin : watchdog
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int change_pix;
    bit changed;

    // Scene A: 2P sky, falling bird, pipe1 with head spans, pipe2 clipped at right edge,
    // pipe3 with gap edge below the head height, coin overlapping the bird.
    vecs.push_back(mk(1, 206, 200, PIPE_C,    "p1_body_above_head"));
    vecs.push_back(mk(1, 207, 200, HEAD_EXP,  "p1_upper_head_top"));
    vecs.push_back(mk(1, 223,  40, SKY_2P_C,  "bird_above"));
    vecs.push_back(mk(1, 224,  55, BIRD_DN_C, "bird_top_right"));
    vecs.push_back(mk(1, 229, 200, HEAD_EXP,  "p1_upper_head_base"));
    vecs.push_back(mk(1, 230,  39, SKY_2P_C,  "bird_left_out"));
    vecs.push_back(mk(1, 230,  40, BIRD_DN_C, "bird_left_edge"));
    vecs.push_back(mk(1, 230,  56, SKY_2P_C,  "bird_right_out"));
    vecs.push_back(mk(1, 233,  60, SKY_2P_C,  "coin_above"));
    vecs.push_back(mk(1, 234,  60, COIN_C,    "coin_top_row"));
    vecs.push_back(mk(1, 236,  50, BIRD_DN_C, "bird_over_coin"));
    vecs.push_back(mk(1, 236,  56, COIN_C,    "coin_right_of_bird"));
    vecs.push_back(mk(1, 236,  60, COIN_C,    "coin_col60"));
    vecs.push_back(mk(1, 236,  61, SKY_2P_C,  "coin_right_out"));
    vecs.push_back(mk(1, 239,  40, BIRD_DN_C, "bird_bottom"));
    vecs.push_back(mk(1, 240,  40, SKY_2P_C,  "bird_below"));
    vecs.push_back(mk(1, 249,  45, COIN_C,    "coin_bottom"));
    vecs.push_back(mk(1, 250,  45, SKY_2P_C,  "coin_below"));
    vecs.push_back(mk(1, 259, 300, HEAD_EXP,  "p3_upper_head"));
    vecs.push_back(mk(1, 319, 200, SKY_2P_C,  "p1_gap_mid"));
    vecs.push_back(mk(1, 329, 200, SKY_2P_C,  "p1_gap_bottom"));
    vecs.push_back(mk(1, 330, 200, HEAD_EXP,  "p1_lower_head_top"));
    vecs.push_back(mk(1, 339, 200, HEAD_EXP,  "p1_lower_head"));
    vecs.push_back(mk(1, 379, 199, SKY_2P_C,  "p1_left_out"));
    vecs.push_back(mk(1, 379, 200, PIPE_C,    "p1_body_low"));
    vecs.push_back(mk(1, 379, 249, PIPE_C,    "p1_right_edge"));
    vecs.push_back(mk(1, 379, 250, SKY_2P_C,  "p1_right_out"));
    vecs.push_back(mk(1, 379, 300, SKY_2P_C,  "p3_gap"));
    vecs.push_back(mk(1, 469, 619, SKY_2P_C,  "p2_left_out"));
    vecs.push_back(mk(1, 469, 620, PIPE_C,    "p2_clip_left"));
    vecs.push_back(mk(1, 469, 639, PIPE_C,    "p2_clip_right"));
    vecs.push_back(mk(1, 474, 300, HEAD_EXP,  "p3_head_clamped"));
    // Inputs change at frame 1 row 476; remainder of frame 1 still shows scene A.
    vecs.push_back(mk(1, 478, 100, SKY_2P_C,  "midframe_new_x_hidden"));
    vecs.push_back(mk(1, 478, 200, PIPE_C,    "midframe_old_x_kept"));
    vecs.push_back(mk(1, 479, 300, HEAD_EXP,  "p3_head_row0"));
    // Scene B: 1P sky, rising bird, coin hidden, pipe1 moved to x=100.
    vecs.push_back(mk(2, 230,  40, BIRD_UP_C, "bird_rising"));
    vecs.push_back(mk(2, 236,  60, SKY_1P_C,  "coin_hidden"));
    vecs.push_back(mk(2, 339, 100, HEAD_EXP,  "p1_new_head"));
    vecs.push_back(mk(2, 379, 100, PIPE_C,    "p1_new_left"));
    vecs.push_back(mk(2, 379, 149, PIPE_C,    "p1_new_right"));
    vecs.push_back(mk(2, 379, 150, SKY_1P_C,  "p1_new_right_out"));
    vecs.push_back(mk(2, 379, 200, SKY_1P_C,  "p1_old_x_gone"));

    status = 2'b10;
    bird_y = 16'd240;
    pipe1  = pipe_word(100, 200, 150);
    pipe2  = pipe_word(50, 620, 300);
    pipe3  = pipe_word(200, 300, 10);
    coin   = coin_word(1'b1, 230, 45);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(rgb), 32'h0);
    check("reset_hsync", 32'(hsync), 32'h1);
    check("reset_vsync", 32'(vsync), 32'h1);
    check("reset_frame_tick", 32'(frame_tick), 32'h0);
    mon_en = 1'b1;
    rst    = 1'b0;

    wait_cyc(FRAME + 3);
    check("f0_hsync_low_cycles", 32'(hs_low_f0), 32'(96 * 525));
    check("f0_vsync_low_cycles", 32'(vs_low_f0), 32'(2 * 800));
    check("f0_sync_errors", 32'(sync_err), 32'h0);
    check("f0_black_errors", 32'(rgb_err), 32'h0);

    change_pix = FRAME + 476 * 800;
    changed    = 1'b0;
    foreach (vecs[i]) begin
      int t;
      t = vecs[i].frame * FRAME + vecs[i].row * 800 + vecs[i].col;
      if (!changed && t >= change_pix) begin
        wait_cyc(change_pix);
        pipe1   = pipe_word(100, 100, 150);
        status  = 2'b00;
        bird_y  = 16'h8000 | 16'd240;
        coin    = coin_word(1'b0, 230, 45);
        changed = 1'b1;
      end
      wait_cyc(t + 2);
      check(vecs[i].name, 32'(rgb), 32'(vecs[i].exp));
    end

    check("tick_count", 32'(ticks), 32'd2);
    check("tick_first_cycle", 32'(first_tick), 32'(479 * 800 + 640));
    check("tick_second_cycle", 32'(last_tick), 32'(FRAME + 479 * 800 + 640));

    // Reset in the middle of frame 2, then the following frame must stay black.
    wait_cyc(2 * FRAME + 400 * 800);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_rgb", 32'(rgb), 32'h0);
    check("midreset_hsync", 32'(hsync), 32'h1);
    check("midreset_vsync", 32'(vsync), 32'h1);
    check("midreset_cycle", 32'(cyc), 32'h0);
    rst = 1'b0;

    wait_cyc(236 * 800 + 50 + 2);
    check("post_reset_bird_black", 32'(rgb), 32'h0);
    wait_cyc(260 * 800);
    check("post_reset_no_tick", 32'(ticks), 32'd2);
    check("total_sync_errors", 32'(sync_err), 32'h0);
    check("total_blank_errors", 32'(rgb_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scene_render.md
# scene_render

Pixel-side consumer of the game state words produced by the game control block. It owns the 640×480@60 VGA raster timing and snapshots the bird, pipe, coin and status words once per frame. For every visible pixel it resolves which object covers it and drives 12-bit RGB and the sync signals. It sits between the control block and the board's VGA connector.

## Interface
- No parameters. Geometry and colour constants come from the shared package.
- `clk` in 1: 25 MHz pixel clock, one pixel per cycle.
- `rst` in 1: synchronous, active-high.
- `status` in 2: game status (00/01 single-player, 10/11 two-player).
- `bird_y` in 16: [14:0] bird bottom edge in game y; [15] = rising.
- `pipe1`, `pipe2`, `pipe3` in 32 each: [27:20] gap, [19:10] left x, [9:0] lower edge of the gap (game y).
- `coin` in 32: [31] visible, [19:10] bottom y, [9:0] left x.
- `hsync`, `vsync` out 1: active-low.
- `rgb` out 12: {R[3:0], G[3:0], B[3:0]}.
- `frame_tick` out 1: one-cycle pulse when a new snapshot is taken.

## Operation
- Counters:
  - `hcnt` runs 0..799 and wraps to 0.
  - `vcnt` increments when `hcnt` wraps, runs 0..524 and wraps to 0.
  - Visible area is `hcnt`<640 and `vcnt`<480.
  - `hsync` is low for `hcnt` 656..751. `vsync` is low for `vcnt` 490..491.
- Snapshot:
  - Taken in the cycle where `hcnt`==639 and `vcnt`==479. All input words are registered, `snap_valid` is set, and `frame_tick` pulses in the following cycle.
  - Inputs are ignored at every other time, so objects never tear mid-frame.
- Coordinate map: game y = 479 − `vcnt`. Game y 0 is the bottom row of the screen.
- Arithmetic: all range sums use 11-bit width. x+50 and y+gap+23 must not wrap, so a pipe at x=640 is fully off-screen and x=620 draws 20 columns.
- Hit tests, each an inclusive-low / exclusive-high span:
  - Bird: x∈[40,56), y∈[bird_y, bird_y+16).
  - Coin: coin[31]=1, x∈[cx, cx+16), y∈[cy, cy+16).
  - Pipe body: x∈[px, px+50) and (y<py or y≥py+gap).
  - Pipe head: pipe body with y∈[py−23, py) or y∈[py+gap, py+gap+23). Evaluate py−23 as signed, so py<23 clamps the lower bound to 0.
- Priority: bird > coin > pipe head > pipe body > sky.
  - Bird colour is BIRD_UP_C when bird_y[15]=1, otherwise BIRD_DN_C.
  - Sky colour is SKY_1P_C when status[1]=0, otherwise SKY_2P_C.
- Blanking:
  - `rgb`=0 outside the visible area.
  - `rgb`=0 while `snap_valid`=0, i.e. after reset until the first snapshot.

## Timing
- Pipeline stages:
  - S0: counters.
  - S1: registered hit flags plus delayed visible/sync.
  - S2: registered colour mux onto `rgb`, `hsync`, `vsync`.
- Outputs lag the counter value by exactly 2 cycles. `hsync`, `vsync` and `rgb` remain mutually aligned.
- Reset behaviour:
  - `hcnt`=`vcnt`=0, all pipeline registers cleared.
  - `rgb`=0, `hsync`=`vsync`=1, `frame_tick`=0.
  - `snap_valid`=0 and all snapshot registers cleared.
- `rst` mid-frame restarts the raster at (0,0) on the next cycle. The first frame after reset is black.
- Input changes during the snapshot cycle: the value present at that clock edge is captured.

## Configuration
- `SCENE_PIPE_HEAD_EN` defined: pipe head spans are tested and drawn in PIPE_HEAD_C.
- `SCENE_PIPE_HEAD_EN` undefined: head logic is omitted and those pixels are drawn as pipe body.
- Latency is identical in both builds.

## Structure
- `scene_pkg` holds:
  - Timing constants: H_VIS, H_TOTAL, HS_START, HS_END, and the V equivalents.
  - Geometry: BIRD_X=40, BIRD_W=16, BIRD_H=16, PIPE_W=50, PIPE_HEAD=23, COIN_LEN=16.
  - Colours: SKY_1P_C, SKY_2P_C, PIPE_C, PIPE_HEAD_C, COIN_C, BIRD_UP_C, BIRD_DN_C.
  - Typedef `pipe_t` packing {gap, x, y}.
- Sub-module `pipe_hit` is instantiated three times. It takes (x, gy, pipe_t) and returns the {body, head} hit bits.

## Test plan
- Reset, run 2 frames: `hsync` low exactly 96 cycles per line; `vsync` low exactly 2 lines per 525; `rgb`=0 throughout frame 0.
- bird_y=240 (rising bit clear), pipes at x=640, coin[31]=0: in frame 1, rows 224..239 and columns 40..55 are BIRD_DN_C; all other visible pixels are SKY_1P_C.
- pipe1={gap 100, x 200, y 150}, status=10: column 200, row 479−100 is PIPE_C; row 479−160 is SKY_2P_C; row 479−140 is PIPE_HEAD_C; column 250 is sky.
- Same stimulus built without `SCENE_PIPE_HEAD_EN`: row 479−140 is PIPE_C.
- Coin at (x 45, y 230, visible) overlapping the bird: overlap pixels are bird colour; coin-only pixels at column 60 are COIN_C.
- Change pipe1.x mid-frame from 200 to 100: the current frame still draws x=200; the next frame draws x=100, and `frame_tick` pulses once per frame.
